// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame constants and datapath widths.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_MIN_BAUD_DIV = 4;
    localparam int unsigned UART_DIV_W        = 16;
    localparam int unsigned UART_IDX_W        = $clog2(UART_DATA_BITS);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_START = 5'b00010,
        S_DATA  = 5'b00100,
        S_STOP  = 5'b01000,
        S_BREAK = 5'b10000
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous line that idles high.
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver front end: start qualification, mid-bit sampling, stop check.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      rx_i,
    input  logic [UART_DIV_W-1:0]     baud_div,
    output logic [UART_DATA_BITS-1:0] dout_o,
    output logic                      rx_done_tick_o,
    output logic                      frame_err_o,
    output logic                      busy_o
);

    logic rx_s;

    uart_state_e               state_q, state_d;
    logic [UART_DIV_W-1:0]     cnt_q, cnt_d;
    logic [UART_DIV_W-1:0]     div_q, div_d;
    logic [UART_IDX_W-1:0]     idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic [UART_DATA_BITS-1:0] dout_q, dout_d;
    logic                      tick_q, tick_d;
    logic                      ferr_q, ferr_d;
    logic                      busy_q, busy_d;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    // Next-state and datapath updates; pulses default low every cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        tick_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s && (baud_div >= UART_DIV_W'(UART_MIN_BAUD_DIV))) begin
                    cnt_d   = '0;
                    div_d   = baud_div;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_q + UART_DIV_W'(1);
                if (cnt_q == (div_q >> 1)) begin
                    if (!rx_s) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + UART_DIV_W'(1);
                if (cnt_q == (div_q - UART_DIV_W'(1))) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[UART_DATA_BITS-1:1]};
                    idx_d = idx_q + UART_IDX_W'(1);
                    if (idx_q == UART_IDX_W'(UART_DATA_BITS - 1)) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + UART_DIV_W'(1);
                if (cnt_q == (div_q - UART_DIV_W'(1))) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        dout_d  = sh_q;
                        tick_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Held-low line must rise before another start can be qualified.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            tick_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            tick_q  <= tick_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign dout_o         = dout_q;
    assign rx_done_tick_o = tick_q;
    assign frame_err_o    = ferr_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: scoreboard of expected bytes and tick cycles.
module tb_uart_rx_deser;

    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx;
    logic [15:0] baud_div;
    logic [7:0]  dout;
    logic        tick;
    logic        ferr;
    logic        busy;

    uart_rx_deser #(
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .rx_i          (rx),
        .baud_div      (baud_div),
        .dout_o        (dout),
        .rx_done_tick_o(tick),
        .frame_err_o   (ferr),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned tick_cnt = 0;
    int unsigned ferr_cnt = 0;
    int unsigned ferr_cyc = 0;
    int unsigned early_ticks = 0;
    int unsigned ign_limit = 0;
    bit          sb_ignore = 1'b0;

    // Expected tick cycle: start-bit edge driven in cycle c, seen by FSM SYNC cycles later.
    function automatic int unsigned due_cycle(input int unsigned c, input int unsigned div);
        return c + SYNC + 2 + (div / 2) + 9 * div;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (tick === 1'b1 || ferr === 1'b1) begin
                n_checks++;
                if ((tick & ferr) !== 1'b0) begin
                    n_errors++;
                    $display("FAIL tick_ferr_overlap cyc=%0d tick=%b ferr=%b required not both", cyc, tick, ferr);
                end
            end
            if (ferr === 1'b1) begin
                ferr_cnt++;
                ferr_cyc = cyc;
            end
            if (tick === 1'b1) begin
                tick_cnt++;
                if (sb_ignore) begin
                    if (cyc <= ign_limit) early_ticks++;
                end else if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_tick cyc=%0d dout=%h required no tick", cyc, dout);
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if (dout !== e.data) begin
                        n_errors++;
                        $display("FAIL tick_data got=%h exp=%h", dout, e.data);
                    end
                    n_checks++;
                    if (cyc !== e.due) begin
                        n_errors++;
                        $display("FAIL tick_time got=%0d exp=%0d", cyc, e.due);
                    end
                end
            end
        end
    endtask

    // Drives one 8N1 frame starting at the current negedge; returns the start cycle.
    task automatic send_frame(input logic [7:0] b, input int unsigned div, input logic stop_bit,
                              input bit expect_tick, output int unsigned c);
        exp_t e;
        rx = 1'b0;
        c  = cyc;
        if (expect_tick) begin
            e.data = b;
            e.due  = due_cycle(c, div);
            sb.push_back(e);
        end
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (div) @(negedge clk);
        end
        rx = stop_bit;
        repeat (div) @(negedge clk);
    endtask

    task automatic wait_drain(input int unsigned budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx = 1'b1;
        baud_div = 16'd16;
        repeat (3) @(negedge clk);
        n_checks++; if (dout !== 8'h00) begin n_errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
        n_checks++; if (tick !== 1'b0) begin n_errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
        n_checks++; if (ferr !== 1'b0) begin n_errors++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int unsigned t0, f0, c;
        baud_div = 16'd16;
        t0 = tick_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 16, 1'b1, 1'b1, c);
        send_frame(8'hA3, 16, 1'b1, 1'b1, c);
        wait_drain(400);
        n_checks++; if (sb.size() !== 0) begin n_errors++; $display("FAIL b2b_pending got=%0d exp=0", sb.size()); end
        n_checks++; if (tick_cnt - t0 !== 2) begin n_errors++; $display("FAIL b2b_ticks got=%0d exp=2", tick_cnt - t0); end
        n_checks++; if (ferr_cnt !== f0) begin n_errors++; $display("FAIL b2b_ferr got=%0d exp=%0d", ferr_cnt, f0); end
        n_checks++; if (dout !== 8'hA3) begin n_errors++; $display("FAIL b2b_dout got=%h exp=A3", dout); end
    endtask

    task automatic test_glitch();
        int unsigned t0, f0, c;
        baud_div = 16'd16;
        t0 = tick_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        c = cyc;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        while (cyc < c + SYNC + 1 + 8) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_drop got=%b exp=0", busy); end
        repeat (40) @(negedge clk);
        n_checks++; if (tick_cnt !== t0) begin n_errors++; $display("FAIL glitch_tick got=%0d exp=%0d", tick_cnt, t0); end
        n_checks++; if (ferr_cnt !== f0) begin n_errors++; $display("FAIL glitch_ferr got=%0d exp=%0d", ferr_cnt, f0); end
    endtask

    task automatic test_break();
        int unsigned t0, f0, c;
        baud_div = 16'd16;
        t0 = tick_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 16, 1'b0, 1'b0, c);
        repeat (50 * 16) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL break_busy got=%b exp=1", busy); end
        repeat (50 * 16) @(negedge clk);
        n_checks++; if (ferr_cnt - f0 !== 1) begin n_errors++; $display("FAIL break_ferr_count got=%0d exp=1", ferr_cnt - f0); end
        n_checks++; if (ferr_cyc !== due_cycle(c, 16)) begin n_errors++; $display("FAIL break_ferr_time got=%0d exp=%0d", ferr_cyc, due_cycle(c, 16)); end
        n_checks++; if (tick_cnt !== t0) begin n_errors++; $display("FAIL break_tick got=%0d exp=%0d", tick_cnt, t0); end
        n_checks++; if (dout !== 8'hA3) begin n_errors++; $display("FAIL break_dout got=%h exp=A3", dout); end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL break_release got=%b exp=0", busy); end
        send_frame(8'h81, 16, 1'b1, 1'b1, c);
        wait_drain(200);
        n_checks++; if (sb.size() !== 0) begin n_errors++; $display("FAIL break_after_pending got=%0d exp=0", sb.size()); end
        n_checks++; if (dout !== 8'h81) begin n_errors++; $display("FAIL break_after_dout got=%h exp=81", dout); end
    endtask

    task automatic test_baud_change();
        int unsigned f0, c;
        baud_div = 16'd16;
        f0 = ferr_cnt;
        fork
            send_frame(8'hF0, 16, 1'b1, 1'b1, c);
            begin
                repeat (60) @(negedge clk);
                baud_div = 16'd32;
            end
        join
        send_frame(8'h0F, 32, 1'b1, 1'b1, c);
        wait_drain(400);
        n_checks++; if (sb.size() !== 0) begin n_errors++; $display("FAIL baud_pending got=%0d exp=0", sb.size()); end
        n_checks++; if (dout !== 8'h0F) begin n_errors++; $display("FAIL baud_dout got=%h exp=0F", dout); end
        n_checks++; if (ferr_cnt !== f0) begin n_errors++; $display("FAIL baud_ferr got=%0d exp=%0d", ferr_cnt, f0); end
    endtask

    task automatic test_reset_mid();
        int unsigned f0, c, c0;
        baud_div = 16'd16;
        f0 = ferr_cnt;
        early_ticks = 0;
        c0 = cyc;
        ign_limit = due_cycle(c0, 16) + 4;
        sb_ignore = 1'b1;
        fork
            send_frame(8'hC7, 16, 1'b1, 1'b0, c);
            begin
                repeat (16 * 5 + 8) @(negedge clk);
                rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                n_checks++; if (dout !== 8'h00) begin n_errors++; $display("FAIL rstmid_dout got=%h exp=00", dout); end
                n_checks++; if (tick !== 1'b0) begin n_errors++; $display("FAIL rstmid_tick got=%b exp=0", tick); end
                n_checks++; if (ferr !== 1'b0) begin n_errors++; $display("FAIL rstmid_ferr got=%b exp=0", ferr); end
                n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
            end
        join
        repeat (120) @(negedge clk);
        sb_ignore = 1'b0;
        n_checks++; if (early_ticks !== 0) begin n_errors++; $display("FAIL rstmid_no_tick got=%0d exp=0", early_ticks); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_idle got=%b exp=0", busy); end
        send_frame(8'h12, 16, 1'b1, 1'b1, c);
        wait_drain(200);
        n_checks++; if (sb.size() !== 0) begin n_errors++; $display("FAIL rstmid_pending got=%0d exp=0", sb.size()); end
        n_checks++; if (dout !== 8'h12) begin n_errors++; $display("FAIL rstmid_dout_after got=%h exp=12", dout); end
    endtask

    task automatic test_min_div();
        int unsigned t0, c, busy_hits;
        busy_hits = 0;
        baud_div = 16'd3;
        t0 = tick_cnt;
        fork
            send_frame(8'h00, 16, 1'b1, 1'b0, c);
            repeat (160) begin
                @(negedge clk);
                if (busy !== 1'b0) busy_hits++;
            end
        join
        send_frame(8'hA5, 3, 1'b1, 1'b0, c);
        repeat (20) @(negedge clk);
        n_checks++; if (busy_hits !== 0) begin n_errors++; $display("FAIL div3_busy got=%0d exp=0", busy_hits); end
        n_checks++; if (tick_cnt !== t0) begin n_errors++; $display("FAIL div3_tick got=%0d exp=%0d", tick_cnt, t0); end
        baud_div = 16'd4;
        @(negedge clk);
        send_frame(8'hE5, 4, 1'b1, 1'b1, c);
        wait_drain(100);
        n_checks++; if (sb.size() !== 0) begin n_errors++; $display("FAIL div4_pending got=%0d exp=0", sb.size()); end
        n_checks++; if (tick_cnt - t0 !== 1) begin n_errors++; $display("FAIL div4_tick got=%0d exp=1", tick_cnt - t0); end
        n_checks++; if (dout !== 8'hE5) begin n_errors++; $display("FAIL div4_dout got=%h exp=E5", dout); end
    endtask

    initial begin
        rstn = 1'b0;
        rx = 1'b1;
        baud_div = 16'd16;
        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog cyc=%0d errors=%0d checks=%0d", cyc, n_errors, n_checks);
                $fatal(1, "timeout");
            end
        join_none
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_glitch();
        test_break();
        test_baud_change();
        test_reset_mid();
        test_min_div();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
